// File: rtl/alu_seq_pkg.sv
// Shared opcode codes and flag-register layout for the sequential ALU.
package alu_seq_pkg;

    localparam int FLAGS_W = 4;

    localparam int CARRY_FLAG = 0;
    localparam int ZERO_FLAG  = 1;
    localparam int NEG_FLAG   = 2;
    localparam int OVF_FLAG   = 3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADC  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SBB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOT  = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_SHR  = 4'd9;
    localparam logic [3:0] ALU_ROL  = 4'd10;
    localparam logic [3:0] ALU_ROR  = 4'd11;
    localparam logic [3:0] ALU_CMP  = 4'd12;
    localparam logic [3:0] ALU_MUL  = 4'd13;
    localparam logic [3:0] ALU_PASS = 4'd14;
    localparam logic [3:0] ALU_RSVD = 4'd15;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the operand source and the ALU.
interface alu_seq_if #(parameter int WIDTH = 8);
    import alu_seq_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           operation;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   out;
    logic [FLAGS_W-1:0]   flags;
    logic                 busy;

    modport master (
        output in_valid, operation, x, y,
        input  in_ready, out_valid, out, flags, busy
    );

    modport slave (
        input  in_valid, operation, x, y,
        output in_ready, out_valid, out, flags, busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier; the last partial sum is presented
// combinationally alongside done so the caller can capture it on that edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] sum;

    assign sum     = acc + (mplier[0] ? mcand : '0);
    assign product = sum;
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, x};
            acc    <= '0;
            mplier <= y;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops finish on the accepting edge, MUL runs
// WIDTH cycles in the multiplier while the request side is held off.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic     clock,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]         state;
    logic [2*WIDTH-1:0] out_q;
    logic [FLAGS_W-1:0] flags_q;
    logic               out_valid_q;

    logic               accept, is_mul, mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     r, xa, ya;
    logic               cin, c, v, wr_out, wr_flags;
    logic [FLAGS_W-1:0] nf, mul_flags;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state == S_MUL);
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = (MUL_EN != 0) && (bus.operation == ALU_MUL);
    assign cin    = flags_q[CARRY_FLAG];
    assign xa     = {1'b0, bus.x};
    assign ya     = {1'b0, bus.y};

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clock   (clock),
                .reset   (reset),
                .start   (accept && is_mul),
                .x       (bus.x),
                .y       (bus.y),
                .done    (mul_done),
                .product (product)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign product  = '0;
        end
    endgenerate

    // Carry/borrow lands in r[WIDTH] for the arithmetic ops.
    always_comb begin
        r        = '0;
        c        = 1'b0;
        v        = 1'b0;
        wr_out   = 1'b1;
        wr_flags = 1'b1;
        case (bus.operation)
            ALU_ADD, ALU_ADC: begin
                r = xa + ya + ((bus.operation == ALU_ADC) ? {{WIDTH{1'b0}}, cin} : '0);
                c = r[WIDTH];
                v = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (r[WIDTH-1] != bus.x[WIDTH-1]);
            end
            ALU_SUB, ALU_SBB, ALU_CMP: begin
                r = xa - ya - ((bus.operation == ALU_SBB) ? {{WIDTH{1'b0}}, cin} : '0);
                c = r[WIDTH];
                v = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (r[WIDTH-1] != bus.x[WIDTH-1]);
                wr_out = (bus.operation != ALU_CMP);
            end
            ALU_AND:  r = xa & ya;
            ALU_OR:   r = xa | ya;
            ALU_XOR:  r = xa ^ ya;
            ALU_NOT:  r = {1'b0, ~bus.x};
            ALU_SHL: begin
                r = {1'b0, bus.x[WIDTH-2:0], 1'b0};
                c = bus.x[WIDTH-1];
            end
            ALU_SHR: begin
                r = {2'b00, bus.x[WIDTH-1:1]};
                c = bus.x[0];
            end
            ALU_ROL: begin
                r = {1'b0, bus.x[WIDTH-2:0], cin};
                c = bus.x[WIDTH-1];
            end
            ALU_ROR: begin
                r = {1'b0, cin, bus.x[WIDTH-1:1]};
                c = bus.x[0];
            end
            ALU_PASS: r = ya;
            default: begin
                wr_out   = 1'b0;
                wr_flags = 1'b0;
            end
        endcase
        nf = {v, r[WIDTH-1], (r[WIDTH-1:0] == '0), c};
    end

    assign mul_flags = {(product[2*WIDTH-1:WIDTH] != '0), product[2*WIDTH-1],
                        (product == '0), 1'b0};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            out_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    if (is_mul) begin
                        state <= S_MUL;
                    end else begin
                        out_valid_q <= 1'b1;
                        if (wr_out)   out_q   <= {{WIDTH{1'b0}}, r[WIDTH-1:0]};
                        if (wr_flags) flags_q <= nf;
                    end
                end
            end else if (mul_done) begin
                out_q       <= product;
                flags_q     <= mul_flags;
                out_valid_q <= 1'b1;
                state       <= S_IDLE;
            end
        end
    end

endmodule
